// File: rtl/div_iter_if.sv
// Divide handshake bundle between the EX stage (master) and the
// iterative divider (slave).
interface div_iter_if #(
  parameter int WIDTH = 32
);

  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU. Operands are reduced
// to magnitudes on acceptance, one quotient bit is produced per cycle,
// and signs are restored when the result is registered. The result is
// {remainder, quotient} and is only non-zero while ready_o is high.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  div_iter_if.slave    bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BYZERO,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 ready_q, ready_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  // Operand magnitudes; the most negative value maps onto itself and is
  // then simply read as an unsigned magnitude.
  logic [WIDTH-1:0]     op1_abs, op2_abs;
  assign op1_abs = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_abs = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  // One restoring step: shift {rem, quo} left, try subtracting the divisor
  // from the widened upper half and keep the difference when it fits.
  logic [WIDTH:0]       upper;
  logic [WIDTH-1:0]     trial;
  logic                 fits;
  logic [WIDTH-1:0]     step_rem, step_quo;
  assign upper    = {rem_q, quo_q[WIDTH-1]};
  assign fits     = (upper >= {1'b0, divisor_q});
  assign trial    = upper[WIDTH-1:0] - divisor_q;
  assign step_rem = fits ? trial : upper[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], fits};

  // Next-state and next-output logic; everything holds by default and the
  // result/ready pair is cleared unless a state explicitly presents it.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = 1'b0;
    result_d  = '0;

    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          neg_quo_d = bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
          neg_rem_d = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
          divisor_d = op2_abs;
          rem_d     = '0;
          quo_d     = op1_abs;
          count_d   = '0;
          state_d   = (bus.opdata2_i == '0) ? BYZERO : RUN;
        end
      end

      RUN: begin
        if (bus.annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {(neg_rem_q ? -step_rem : step_rem),
                        (neg_quo_q ? -step_quo : step_quo)};
          end
        end
      end

      BYZERO: begin
        if (bus.annul_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          ready_d = 1'b1;
        end
      end

      DONE: begin
        if (bus.annul_i) begin
          state_d = IDLE;
        end else if (bus.start_i) begin
          ready_d  = 1'b1;
          result_d = result_q;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Testbench for div_iter: directed corner cases, annul/reset aborts and
// randomized DIV/DIVU vectors checked through a result scoreboard.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst;

  // 100 MHz-style free running clock.
  always #5 clk = ~clk;

  div_iter_if dif ();

  div_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  logic [63:0] sb_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: signed division truncates toward zero and the remainder
  // takes the dividend's sign; the one overflowing case wraps.
  function automatic logic [63:0] ref_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge with the DUT idle. Holds start until ready, checks
  // latency and result, then drops start and checks the return to idle.
  task automatic applyStimulus(input string tag, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input bit scramble);
    int lat;
    int exp_lat;
    logic [63:0] expv;
    sb_q.push_back(ref_model(sgn, a, b));
    exp_lat = (b == 32'd0) ? 2 : 33;
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.annul_i      = 1'b0;
    dif.start_i      = 1'b1;
    lat = -1;
    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      @(negedge clk);
      if (scramble) begin
        dif.opdata1_i    = $urandom;
        dif.opdata2_i    = $urandom;
        dif.signed_div_i = 1'($urandom_range(0, 1));
      end
      if (dif.ready_o) lat = cyc;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
    expv = sb_q.pop_front();
    if (lat > 0) checkOutput({tag, " result"}, dif.result_o, expv);
    dif.start_i = 1'b0;
    @(negedge clk);
    if (lat < 0) begin
      dif.annul_i = 1'b1;
      @(negedge clk);
      dif.annul_i = 1'b0;
    end
    checkOutput({tag, " idle ready"}, 64'(dif.ready_o), 64'd0);
    checkOutput({tag, " idle result"}, dif.result_o, 64'd0);
  endtask

  // Hard time limit so a stuck handshake can never hang the run.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    bit seen;
    logic sgn;
    logic [31:0] a, b;

    rst = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset ready", 64'(dif.ready_o), 64'd0);
    checkOutput("reset result", dif.result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("u 7/2", 1'b0, 32'd7, 32'd2, 1'b0);
    applyStimulus("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    applyStimulus("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    applyStimulus("s div0", 1'b1, 32'h1234, 32'd0, 1'b0);
    applyStimulus("u div0", 1'b0, 32'h1234, 32'd0, 1'b0);
    applyStimulus("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);

    // Annul during RUN: no ready pulse may follow.
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd3;
    dif.start_i      = 1'b1;
    repeat (10) @(negedge clk);
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);
    dif.annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o) seen = 1'b1;
    end
    checkOutput("annul run no ready", 64'(seen), 64'd0);
    applyStimulus("u 100/7", 1'b0, 32'd100, 32'd7, 1'b0);

    // Annul while idle must block acceptance.
    dif.opdata1_i = 32'd50;
    dif.opdata2_i = 32'd5;
    dif.start_i   = 1'b1;
    dif.annul_i   = 1'b1;
    repeat (3) @(negedge clk);
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o) seen = 1'b1;
    end
    checkOutput("annul idle no ready", 64'(seen), 64'd0);

    // Annul in DONE overrides a still-high start.
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd9;
    dif.opdata2_i    = 32'd0;
    dif.start_i      = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("done ready", 64'(dif.ready_o), 64'd1);
    dif.annul_i = 1'b1;
    @(negedge clk);
    checkOutput("annul done ready", 64'(dif.ready_o), 64'd0);
    dif.annul_i = 1'b0;
    dif.start_i = 1'b0;
    @(negedge clk);

    // Synchronous reset in the middle of RUN.
    dif.opdata1_i = 32'd5000;
    dif.opdata2_i = 32'd13;
    dif.start_i   = 1'b1;
    repeat (20) @(negedge clk);
    rst         = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid reset ready", 64'(dif.ready_o), 64'd0);
    checkOutput("mid reset result", dif.result_o, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o) seen = 1'b1;
    end
    checkOutput("mid reset no ready", 64'(seen), 64'd0);
    applyStimulus("post reset", 1'b1, 32'hFFFF_FC18, 32'd7, 1'b0);

    // Randomized vectors with operand scrambling after acceptance.
    for (int i = 0; i < 1000; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        4: b = 32'($urandom_range(1, 1000)) | 32'h8000_0000;
        default: ;
      endcase
      applyStimulus("rand", sgn, a, b, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
